// File: rtl/cont_bcd2_pkg.sv
// Shared constants and helpers for the two-digit BCD counter.
// Holds digit limits and the load-value validity check.
package cont_bcd2_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ZERO      = 4'd0;

  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[7:4] <= BCD_DIGIT_MAX) &&
           (v[3:0] <= BCD_DIGIT_MAX) &&
           (v <= max);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit built from four JK cells with excitation logic.
// Ports: clk, cnt, up, ld, dval[3:0], clr -> q[3:0], carry, borrow.
module bcd_digit
  import cont_bcd2_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       cnt,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] dval,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] q_d;
  logic [3:0] j;
  logic [3:0] k;

  always_comb begin
    q_d = q;
    if (ld) begin
      q_d = dval;
    end else if (cnt) begin
      if (up) begin
        q_d = (q == BCD_DIGIT_MAX) ? BCD_ZERO : q + 4'd1;
      end else begin
        q_d = (q == BCD_ZERO) ? BCD_DIGIT_MAX : q - 4'd1;
      end
    end
  end

  // Excitation: drive J/K so each cell lands on q_d.
  assign j = q_d & ~q;
  assign k = ~q_d & q;

  for (genvar i = 0; i < 4; i++) begin : g_ff
    ff_jk u_ff (
      .clk (clk),
      .pr  (1'b1),
      .clr (clr),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  // Ripple outputs: asserted when this digit rolls over.
  assign carry  = cnt & up & (q == BCD_DIGIT_MAX);
  assign borrow = cnt & ~up & (q == BCD_ZERO);

endmodule

// File: rtl/ff_jk.sv
// JK flip-flop, synchronous active-low clear and preset.
// Ports: clk, pr (preset, low), clr (clear, low), j, k -> q.
module ff_jk (
  input  logic clk,
  input  logic pr,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q <= 1'b0;
    end else if (!pr) begin
      q_q <= 1'b1;
    end else begin
      unique case ({j, k})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cont_bcd2.sv
// Two-digit BCD up/down counter with load, wrap and error flags.
// Ports: clk, clr, en, up, ld, d[7:0] -> q[7:0], tc, ovf, err.
module cont_bcd2
  import cont_bcd2_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       tc,
  output logic       ovf,
  output logic       err
);

  logic [3:0] u_q;
  logic [3:0] t_q;
  logic       u_carry;
  logic       u_borrow;
  logic       t_borrow;
  logic       unused_t_carry;
  logic       t_cnt;
  logic       d_ok;
  logic       wrap_up;
  logic       wrap;
  logic       dig_ld;
  logic [7:0] dig_val;
  logic       ovf_q;
  logic       ovf_d;
  logic       err_q;
  logic       err_d;

  assign q     = {t_q, u_q};
  assign d_ok  = bcd_ok(d, MAX_BCD);
  assign t_cnt = u_carry | u_borrow;

  // t_borrow already means en & down & q==00.
  assign wrap_up = en & up & (q == MAX_BCD);
  assign wrap    = wrap_up | t_borrow;
  assign tc      = ~ld & wrap;

  // Wraps reuse the digit load path.
  always_comb begin
    dig_ld  = ld | wrap;
    dig_val = 8'h00;
    if (ld) begin
      dig_val = d_ok ? d : 8'h00;
    end else if (t_borrow) begin
      dig_val = MAX_BCD;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (ld) begin
      ovf_d = 1'b0;
      err_d = ~d_ok;
    end else if (wrap) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign ovf = ovf_q;
  assign err = err_q;

  bcd_digit u_units (
    .clk    (clk),
    .clr    (clr),
    .cnt    (en),
    .up     (up),
    .ld     (dig_ld),
    .dval   (dig_val[3:0]),
    .q      (u_q),
    .carry  (u_carry),
    .borrow (u_borrow)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .clr    (clr),
    .cnt    (t_cnt),
    .up     (up),
    .ld     (dig_ld),
    .dval   (dig_val[7:4]),
    .q      (t_q),
    .carry  (unused_t_carry),
    .borrow (t_borrow)
  );

endmodule

// File: tb/tb_cont_bcd2.sv
// Self-checking bench for cont_bcd2: vector table plus
// hand sequences for full-range counts and a reduced MAX_BCD.
module tb_cont_bcd2;

  logic       clk = 1'b0;
  logic       clr, en, up, ld;
  logic [7:0] d;
  logic [7:0] q;
  logic       tc, ovf, err;

  logic       b_clr, b_en, b_up, b_ld;
  logic [7:0] b_d;
  logic [7:0] b_q;
  logic       b_tc, b_ovf, b_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cont_bcd2 u_dut (
    .clk (clk), .clr (clr), .en (en), .up (up),
    .ld  (ld),  .d   (d),   .q  (q),  .tc (tc),
    .ovf (ovf), .err (err)
  );

  cont_bcd2 #(.MAX_BCD(8'h23)) u_dut23 (
    .clk (clk),   .clr (b_clr), .en (b_en), .up (b_up),
    .ld  (b_ld),  .d   (b_d),   .q  (b_q),  .tc (b_tc),
    .ovf (b_ovf), .err (b_err)
  );

  typedef struct {
    logic       clr, ld, en, up;
    logic [7:0] d;
    logic       tc;
    logic [7:0] q;
    logic       ovf, err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Apply inputs, check tc before the edge, outputs after it.
  task automatic step(input logic c, input logic l, input logic e,
                      input logic u, input logic [7:0] dv,
                      input logic etc, input logic [7:0] eq,
                      input logic eo, input logic ee, input string nm);
    clr = c; ld = l; en = e; up = u; d = dv;
    #1;
    chk({nm, ".tc"}, {7'd0, tc}, {7'd0, etc});
    @(posedge clk); #1;
    chk({nm, ".q"},   q, eq);
    chk({nm, ".ovf"}, {7'd0, ovf}, {7'd0, eo});
    chk({nm, ".err"}, {7'd0, err}, {7'd0, ee});
  endtask

  task automatic stepb(input logic c, input logic l, input logic e,
                       input logic u, input logic [7:0] dv,
                       input logic etc, input logic [7:0] eq,
                       input logic eo, input logic ee, input string nm);
    b_clr = c; b_ld = l; b_en = e; b_up = u; b_d = dv;
    #1;
    chk({nm, ".tc"}, {7'd0, b_tc}, {7'd0, etc});
    @(posedge clk); #1;
    chk({nm, ".q"},   b_q, eq);
    chk({nm, ".ovf"}, {7'd0, b_ovf}, {7'd0, eo});
    chk({nm, ".err"}, {7'd0, b_err}, {7'd0, ee});
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; d = 8'h00;
    b_clr = 1'b0; b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_d = 8'h00;
    //        clr  ld   en   up   d      tc   q      ovf  err
    vt.push_back('{0, 1, 1, 1, 8'h55, 0, 8'h00, 0, 0});
    vt.push_back('{1, 1, 0, 1, 8'h3A, 0, 8'h00, 0, 1});
    vt.push_back('{1, 1, 0, 1, 8'h42, 0, 8'h42, 0, 0});
    vt.push_back('{1, 1, 0, 1, 8'h9A, 0, 8'h00, 0, 1});
    vt.push_back('{1, 1, 0, 1, 8'hA0, 0, 8'h00, 0, 1});
    vt.push_back('{1, 1, 1, 1, 8'h57, 0, 8'h57, 0, 0});
    vt.push_back('{1, 0, 0, 1, 8'h00, 0, 8'h57, 0, 0});
    vt.push_back('{0, 1, 1, 1, 8'h88, 0, 8'h00, 0, 0});
    vt.push_back('{1, 0, 1, 1, 8'h00, 0, 8'h01, 0, 0});
    vt.push_back('{1, 1, 0, 1, 8'h09, 0, 8'h09, 0, 0});
    vt.push_back('{1, 0, 1, 1, 8'h00, 0, 8'h10, 0, 0});
    vt.push_back('{1, 0, 1, 0, 8'h00, 0, 8'h09, 0, 0});
    vt.push_back('{1, 0, 1, 1, 8'h00, 0, 8'h10, 0, 0});
    vt.push_back('{1, 1, 1, 1, 8'h05, 0, 8'h05, 0, 0});
    vt.push_back('{1, 1, 0, 1, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{1, 0, 1, 0, 8'h00, 1, 8'h99, 1, 0});
    vt.push_back('{1, 0, 0, 1, 8'h00, 0, 8'h99, 1, 0});
    vt.push_back('{1, 0, 1, 1, 8'h00, 1, 8'h00, 1, 0});
    vt.push_back('{1, 0, 1, 1, 8'h00, 0, 8'h01, 1, 0});
    vt.push_back('{1, 1, 1, 1, 8'h3A, 0, 8'h00, 0, 1});
    vt.push_back('{1, 0, 1, 1, 8'h00, 0, 8'h01, 0, 1});
    vt.push_back('{1, 1, 0, 1, 8'h99, 0, 8'h99, 0, 0});
    vt.push_back('{1, 0, 1, 0, 8'h00, 0, 8'h98, 0, 0});
    vt.push_back('{1, 1, 0, 0, 8'h40, 0, 8'h40, 0, 0});
    vt.push_back('{1, 0, 1, 0, 8'h00, 0, 8'h39, 0, 0});

    @(posedge clk); #1;
    // First row is a reset; tc is unchecked before it.
    clr = vt[0].clr; ld = vt[0].ld; en = vt[0].en;
    up = vt[0].up; d = vt[0].d;
    @(posedge clk); #1;
    chk("v0.q", q, vt[0].q);
    chk("v0.ovf", {7'd0, ovf}, {7'd0, vt[0].ovf});
    chk("v0.err", {7'd0, err}, {7'd0, vt[0].err});
    for (int i = 1; i < vt.size(); i++) begin
      step(vt[i].clr, vt[i].ld, vt[i].en, vt[i].up, vt[i].d,
           vt[i].tc, vt[i].q, vt[i].ovf, vt[i].err,
           $sformatf("v%0d", i));
    end

    // Full up-count through the wrap.
    step(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, "up.rst");
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 1, 1, 8'h00, (i == 99), to_bcd((i + 1) % 100),
           (i == 99), 0, $sformatf("up%0d", i));
    end

    // Down-count from 10 through the wrap.
    step(1, 1, 0, 0, 8'h10, 0, 8'h10, 0, 0, "dn.ld");
    for (int k = 0; k < 12; k++) begin
      step(1, 0, 1, 0, 8'h00, (k == 10),
           (k < 10) ? to_bcd(9 - k) : to_bcd(109 - k),
           (k >= 10), 0, $sformatf("dn%0d", k));
    end

    // Reduced terminal count of 23.
    stepb(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, "m.rst");
    stepb(1, 1, 0, 1, 8'h24, 0, 8'h00, 0, 1, "m.ld24");
    stepb(1, 1, 0, 1, 8'h22, 0, 8'h22, 0, 0, "m.ld22");
    stepb(1, 0, 1, 1, 8'h00, 0, 8'h23, 0, 0, "m.up23");
    stepb(1, 0, 1, 1, 8'h00, 1, 8'h00, 1, 0, "m.wrap");
    stepb(1, 0, 1, 0, 8'h00, 1, 8'h23, 1, 0, "m.dnwrap");
    stepb(1, 1, 0, 1, 8'h09, 0, 8'h09, 0, 0, "m.ld09");
    stepb(1, 0, 1, 1, 8'h00, 0, 8'h10, 0, 0, "m.up10");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cont_bcd2.md
CONT_BCD2 -- requirements
Module: cont_bcd2

Interface
REQ-001 Parameter MAX_BCD, default 8'h99, terminal count in packed BCD (tens nibble, units nibble); each nibble SHALL be 0-9.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr  input  1  reset is synchronous and active-low; clr=0 at a rising edge clears the block.
REQ-004 en  input  1  count enable.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 ld  input  1  synchronous parallel load strobe.
REQ-007 d  input  8  load value, packed BCD {tens, units}.
REQ-008 q  output  8  registered count, packed BCD {tens, units}.
REQ-009 tc  output  1  combinational terminal-count / cascade carry.
REQ-010 ovf  output  1  registered sticky wrap flag.
REQ-011 err  output  1  registered flag: last load value was rejected.

Function
REQ-012 Priority at each rising edge: clr=0, then ld=1, then en=1, else hold.
REQ-013 Latency one cycle: q reflects the action taken at the preceding edge.
REQ-014 en=1, up=1, q<MAX_BCD: q becomes q+1 in BCD; units 9->0 carries into tens.
REQ-015 en=1, up=1, q==MAX_BCD: q becomes 8'h00 and ovf set to 1.
REQ-016 en=1, up=0, q>00: q becomes q-1 in BCD; units 0->9 borrows from tens.
REQ-017 en=1, up=0, q==00: q becomes MAX_BCD and ovf set to 1.
REQ-018 en=0, ld=0: q, ovf and err hold.
REQ-019 ld=1 with d valid (both nibbles <=9 and d<=MAX_BCD): q<=d, err<=0, ovf<=0, regardless of en.
REQ-020 ld=1 with d invalid: q<=8'h00, err<=1, ovf<=0.
REQ-021 ovf is sticky; cleared only by reset or by any load.
REQ-022 err changes only on load or reset; counting never alters err.
REQ-023 tc = en & ~ld & ((up & q==MAX_BCD) | (~up & q==8'h00)); no registered delay.
REQ-024 Direction change takes effect at the next enabled edge; no idle cycle required.
REQ-025 q SHALL never hold a non-BCD nibble or a value above MAX_BCD at any edge after reset.
REQ-026 Before the first reset, outputs are undefined; the bench SHALL not check them.

Reset
REQ-027 clr=0 at a rising edge: q=8'h00, ovf=0, err=0, regardless of ld, en, up and d.
REQ-028 Reset asserted mid-count aborts the count at that edge; counting resumes from 00 at the first edge with clr=1.
REQ-029 tc during reset follows REQ-023 from the current q; it is valid again one cycle after clr returns to 1.

Structure
REQ-030 The shared package SHALL hold BCD_DIGIT_MAX=4'd9, BCD_ZERO=4'd0 and the BCD-validity check function.
REQ-031 One sub-module SHALL be used: bcd_digit.
REQ-032 bcd_digit: one 4-bit BCD digit with inputs cnt, up, ld, dval, clr and outputs q, carry, borrow.
REQ-033 bcd_digit storage: four ff_jk cells, pr tied to 1, clr shared; next-state driven by J/K excitation logic (J=K=1 toggle, J=0,K=1 clear, J=1,K=0 set, J=K=0 hold).
REQ-034 cont_bcd2 instantiates two bcd_digit instances: tens cnt = en & units boundary (9 when up, 0 when down).
REQ-035 Wrap to MAX_BCD/00, ovf, err and load validation SHALL be resolved in cont_bcd2, not in bcd_digit.

Verification
REQ-036 Reset, then en=1, up=1 for 100 cycles: q steps 00,01..99,00; ovf=1 from the 00 after 99; tc=1 only while q=99.
REQ-037 ld=1, d=8'h10, then en=1, up=0 for 12 cycles: q 10,09..00,99,98; ovf=1 after 00->99.
REQ-038 ld=1, d=8'h3A: q=00, err=1; next ld with d=8'h42: q=42, err=0, ovf=0.
REQ-039 MAX_BCD=8'h23, ld with d=8'h24: err=1, q=00; count up from 22: 23, 00 with ovf=1.
REQ-040 q=57, en=1, clr=0 held with ld=1, d=8'h88: q=00, ovf=0, err=0; clr=1 next: q=01.
REQ-041 q=09, en=1: toggle up between consecutive cycles: q 10, 09, 10; ld=1 together with en=1, d=8'h05: q=05, tc=0 during that cycle.
